// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for stream_mux_rr
package stream_mux_pkg;
   localparam int DEFAULT_WIDTH = 64;
   localparam int MAX_N = 16;
   function automatic int src_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: one-hot grant, lowest-index or round-robin search starting at ptr
module rr_arbiter import stream_mux_pkg::*; #(
   parameter int N = 2,
   localparam int SW = src_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          rr_en,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] idx
);
   logic [SW-1:0] c;
   logic found;
   always_comb begin
      grant = '0;
      idx = '0;
      found = 1'b0;
      c = '0;
      for (int k = 0; k < N; k++) begin
         c = rr_en ? SW'((int'(ptr) + k) % N) : SW'(k);
         if (!found && req[c]) begin
            found = 1'b1;
            grant[c] = 1'b1;
            idx = c;
         end
      end
   end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 stream mux, registered output stage, fixed or round-robin arbitration.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr import stream_mux_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N = 2,
   localparam int SW = src_w(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   input  logic               rr_en,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic [SW-1:0]      out_src,
   output logic               out_valid,
   input  logic               out_ready
);
   logic [N-1:0] req, grant;
   logic [SW-1:0] idx, ptr, ptr_nxt;
   logic load_en, acc;
   assign load_en = !out_valid || out_ready;
   assign in_ready = (load_en && rst_n) ? grant : '0;
   assign acc = load_en && |grant;
   assign ptr_nxt = (idx == SW'(N - 1)) ? '0 : idx + 1'b1;
   rr_arbiter #(.N(N)) u_arb (
      .req(req),
      .ptr(ptr),
      .rr_en(rr_en),
      .grant(grant),
      .idx(idx)
   );
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic lock;
   logic [SW-1:0] lock_src;
   // while locked only the owning channel may request, so rr_en has no effect
   assign req = lock ? (in_valid & (N'(1) << lock_src)) : in_valid;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lock <= 1'b0;
         lock_src <= '0;
         ptr <= '0;
      end else if (acc) begin
         lock <= !in_last[idx];
         lock_src <= idx;
         if (in_last[idx]) ptr <= ptr_nxt;
      end
`else
   assign req = in_valid;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (acc) ptr <= ptr_nxt;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_data <= '0;
         out_src <= '0;
      end else begin
         if (load_en) out_valid <= acc;
         if (acc) begin
            out_data <= in_data[int'(idx)*WIDTH +: WIDTH];
            out_last <= in_last[idx];
            out_src <= idx;
         end
      end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: randomized and directed checks of stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
   localparam int N = 4, W = 64;
   logic clk = 0, rst_n = 1, rr_en = 1, out_ready = 1;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0] in_valid = '0, in_last = '0, in_ready, ir_seen;
   logic [W-1:0] out_data, m_data;
   logic out_last, out_valid;
   logic [1:0] out_src;
   int compared = 0, mismatched = 0;
   bit m_valid = 0, m_last = 0, m_lock = 0;
   int m_src = 0, m_ptr = 0, m_lsrc = 0, acc_ch = -1, cnt;
   int rr_exp[5] = '{0, 1, 2, 3, 0};
`ifdef STREAM_MUX_PKT_LOCK_EN
   int pkt_exp[4] = '{1, 1, 1, 0};
`else
   int pkt_exp[4] = '{1, 0, 1, 0};
`endif
   always #5 clk = ~clk;
   stream_mux_rr #(.WIDTH(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .rr_en(rr_en),
      .out_data(out_data), .out_last(out_last), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready)
   );
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int pick();
      if (m_lock) return in_valid[m_lsrc] ? m_lsrc : -1;
      for (int k = 0; k < N; k++) begin
         int c = rr_en ? (m_ptr + k) % N : k;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction
   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic rr, input logic ordy);
      for (int i = 0; i < N * W / 32; i++) in_data[i*32 +: 32] = $urandom;
      in_valid = v;
      in_last = l;
      rr_en = rr;
      out_ready = ordy;
   endtask
   task automatic step();
      int g;
      bit load;
      #1;
      g = pick();
      load = !m_valid || out_ready;
      ir_seen = in_ready;
      check("in_ready", W'(in_ready), (load && g >= 0) ? (W'(1) << g) : W'(0));
      acc_ch = -1;
      if (load) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            acc_ch = g;
            m_data = in_data[g*W +: W];
            m_last = in_last[g];
            m_src = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
            m_lock = !in_last[g];
            m_lsrc = g;
            if (in_last[g]) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
         end
      end
      @(negedge clk);
      check("out_valid", W'(out_valid), W'(m_valid));
      if (m_valid) begin
         check("out_data", out_data, m_data);
         check("out_last", W'(out_last), W'(m_last));
         check("out_src", W'(out_src), W'(m_src));
      end
   endtask
   task automatic do_reset();
      #2 rst_n = 0;
      #1;
      check("rst_out_valid", W'(out_valid), 0);
      check("rst_in_ready", W'(in_ready), 0);
      check("rst_out_src", W'(out_src), 0);
      check("rst_out_data", out_data, 0);
      m_valid = 0;
      m_ptr = 0;
      m_lock = 0;
      m_lsrc = 0;
      @(negedge clk);
      rst_n = 1;
   endtask
   initial begin
      @(negedge clk);
      do_reset();
      repeat (5) begin
         drive('0, '0, 1, 1);
         step();
         check("idle_valid", W'(out_valid), 0);
         check("idle_ready", W'(ir_seen), 0);
      end
      foreach (rr_exp[k]) begin
         drive('1, '1, 1, 1);
         step();
         check("rr_src", W'(out_src), W'(rr_exp[k]));
      end
      repeat (4) begin
         drive(4'b0110, '1, 0, 1);
         step();
         check("fixed_src", W'(out_src), 1);
      end
      drive(4'b0001, '1, 1, 1);
      in_data[63:0] = 64'hDEADBEEF_00000001;
      step();
      check("bp_load", out_data, 64'hDEADBEEF_00000001);
      repeat (3) begin
         drive(4'b0001, '1, 1, 0);
         in_data[63:0] = 64'hDEADBEEF_00000002;
         step();
         check("bp_hold", out_data, 64'hDEADBEEF_00000001);
         check("bp_ready", W'(ir_seen), 0);
      end
      drive(4'b0001, '1, 1, 1);
      in_data[63:0] = 64'hDEADBEEF_00000002;
      step();
      check("bp_release", out_data, 64'hDEADBEEF_00000002);
      drive('0, '0, 1, 1);
      step();
      check("bp_drain", W'(out_valid), 0);
      do_reset();
      cnt = 0;
      foreach (pkt_exp[k]) begin
         drive({2'b00, cnt < 3, k > 0}, {2'b00, cnt == 2, 1'b1}, 1, 1);
         step();
         if (acc_ch == 1) cnt++;
         check("pkt_src", W'(out_src), W'(pkt_exp[k]));
      end
      drive('1, '1, 1, 0);
      step();
      check("mid_valid", W'(out_valid), 1);
      do_reset();
      drive('1, '1, 1, 1);
      step();
      check("post_rst_src", W'(out_src), 0);
      repeat (3000) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         drive(N'($urandom), N'($urandom), ($urandom_range(0, 7) == 0) ? !rr_en : rr_en,
               $urandom_range(0, 3) != 0);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
